// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the FIFO datapath controller: FSM encoding,
// reset thresholds and the destination field carried in each word.
package fifo_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    localparam int ALTO_RST = 6;
    localparam int BAJO_RST = 1;

    // Destination index lives in the DEST_W most significant bits of a word.
    localparam int DEST_W = 2;

    // Starting here makes port 0 the first winner after reset.
    localparam logic [1:0] PTR_RST = 2'd3;

    function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/fifo_arbiter_ctrl_rr_arbiter4.sv
// Four-way round-robin arbiter: grants the first eligible index after ptr,
// wrapping around, with ptr itself considered last.
module rr_arbiter4 (
    input  logic [3:0] eligible,
    input  logic [1:0] ptr,
    output logic [3:0] grant,
    output logic       valid
);

    always_comb begin
        // NOTE: every always_comb output gets a default first, otherwise paths
        // that skip an assignment would infer a latch.
        grant = '0;
        valid = |eligible;
        // Walk from farthest to nearest so the nearest eligible index wins.
        for (int k = 4; k >= 1; k--) begin
            logic [1:0] idx;
            idx = ptr + 2'(k);
            if (eligible[idx]) grant = 4'b0001 << idx;
        end
    end

endmodule

// File: rtl/fifo_arbiter_ctrl.sv
// Controller between four input FIFOs and four output FIFOs: round-robin pops,
// routing by destination field, stall on backpressure, thresholds and overflow error.
module fifo_arbiter_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 10,
    parameter int THR_WIDTH  = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    init,
    input  logic [THR_WIDTH-1:0]    umbral_alto_in,
    input  logic [THR_WIDTH-1:0]    umbral_bajo_in,
    input  logic [3:0]              in_empty,
    input  logic [4*DATA_WIDTH-1:0] in_data,
    output logic [3:0]              in_pop,
    input  logic [3:0]              out_full,
    input  logic [3:0]              out_almost_full,
    output logic [3:0]              out_push,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [THR_WIDTH-1:0]    alto,
    output logic [THR_WIDTH-1:0]    bajo,
    output logic [2:0]              state,
    output logic                    idle,
    output logic                    error
);

    state_t                 state_q;
    logic                   idle_q;
    logic                   error_q;
    logic [THR_WIDTH-1:0]   alto_q, bajo_q;
    logic [THR_WIDTH-1:0]   alto_ok_q, bajo_ok_q;
    logic [3:0]             pop_q;
    logic [3:0]             hist1_q;
    logic [1:0]             ptr_q;
    logic [3:0]             push_q;
    logic [DATA_WIDTH-1:0]  data_q;

    logic                   stall;
    logic                   err_hit;
    logic                   pipe_busy;
    logic                   issue_en;
    logic                   thr_ok;
    logic [1:0]             ptr_eff;
    logic [3:0]             eligible;
    logic [3:0]             grant;
    logic                   grant_valid;
    logic [1:0]             s1_idx;
    logic [DATA_WIDTH-1:0]  slot_word;
    logic [DEST_W-1:0]      dest;

    assign stall     = (|out_almost_full) | (|out_full);
    // The pop decision is registered, but a stall appearing now still cancels it.
    assign in_pop    = pop_q & {4{~stall}};
    assign err_hit   = |(push_q & out_full);
    assign pipe_busy = (|pop_q) | (|hist1_q);
    assign thr_ok    = umbral_bajo_in < umbral_alto_in;

    // Pointer tracks the last pop that actually happened, including this cycle's.
    assign ptr_eff  = (|in_pop) ? onehot_to_idx(in_pop) : ptr_q;
    // Next-cycle pop must avoid ports popped this cycle and last cycle.
    assign eligible = ~in_empty & ~in_pop & ~hist1_q;
    assign issue_en = !stall && (state_q == ST_ACTIVE || (state_q == ST_IDLE && !init));

    rr_arbiter4 u_arb (
        .eligible (eligible),
        .ptr      (ptr_eff),
        .grant    (grant),
        .valid    (grant_valid)
    );

    assign s1_idx    = onehot_to_idx(hist1_q);
    assign slot_word = in_data[int'(s1_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign dest      = slot_word[DATA_WIDTH-1 -: DEST_W];

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!reset) begin
            state_q   <= ST_RESET;
            idle_q    <= 1'b0;
            error_q   <= 1'b0;
            alto_q    <= THR_WIDTH'(ALTO_RST);
            bajo_q    <= THR_WIDTH'(BAJO_RST);
            alto_ok_q <= THR_WIDTH'(ALTO_RST);
            bajo_ok_q <= THR_WIDTH'(BAJO_RST);
            pop_q     <= '0;
            hist1_q   <= '0;
            ptr_q     <= PTR_RST;
            push_q    <= '0;
            data_q    <= '0;
        end else begin
            hist1_q <= in_pop;
            ptr_q   <= ptr_eff;
            pop_q   <= (issue_en && grant_valid) ? grant : '0;
            push_q  <= '0;
            if (|hist1_q) begin
                push_q <= 4'b0001 << dest;
                data_q <= slot_word;
            end

            case (state_q)
                ST_RESET: state_q <= ST_INIT;
                ST_INIT: begin
                    alto_q <= umbral_alto_in;
                    bajo_q <= umbral_bajo_in;
                    if (!init) begin
                        state_q <= ST_IDLE;
                        idle_q  <= 1'b1;
                        if (thr_ok) begin
                            alto_ok_q <= umbral_alto_in;
                            bajo_ok_q <= umbral_bajo_in;
                        end else begin
                            alto_q <= alto_ok_q;
                            bajo_q <= bajo_ok_q;
                        end
                    end
                end
                ST_IDLE: begin
                    if (init) begin
                        state_q <= ST_INIT;
                        idle_q  <= 1'b0;
                    end else if (in_empty != 4'hF && !stall) begin
                        state_q <= ST_ACTIVE;
                        idle_q  <= 1'b0;
                    end
                end
                ST_ACTIVE: begin
                    if (in_empty == 4'hF && !pipe_busy) begin
                        state_q <= ST_IDLE;
                        idle_q  <= 1'b1;
                    end
                end
                // No pops are issued here, so the pipeline stays empty until reset.
                ST_ERROR: state_q <= ST_ERROR;
                default:  state_q <= ST_RESET;
            endcase

            // Overflow drops the offending word and flushes everything in flight.
            if (err_hit) begin
                state_q <= ST_ERROR;
                idle_q  <= 1'b0;
                error_q <= 1'b1;
                pop_q   <= '0;
                hist1_q <= '0;
                push_q  <= '0;
            end
        end
    end

    assign out_push = push_q;
    assign out_data = data_q;
    assign alto     = alto_q;
    assign bajo     = bajo_q;
    assign state    = state_q;
    assign idle     = idle_q;
    assign error    = error_q;

endmodule

// File: tb/tb_fifo_arbiter_ctrl.sv
// Directed self-checking bench for fifo_arbiter_ctrl: thresholds, routing,
// round-robin order, stall, overflow error and reset abort.
module tb_fifo_arbiter_ctrl;

    localparam int DW = 10;
    localparam int TW = 3;

    logic            clk;
    logic            reset;
    logic            init;
    logic [TW-1:0]   ua, ub;
    logic [3:0]      in_empty;
    logic [4*DW-1:0] in_data;
    logic [3:0]      in_pop;
    logic [3:0]      out_full;
    logic [3:0]      out_afull;
    logic [3:0]      out_push;
    logic [DW-1:0]   out_data;
    logic [TW-1:0]   alto, bajo;
    logic [2:0]      state;
    logic            idle;
    logic            error;

    int n_assert = 0;
    int n_fail   = 0;

    // Cycles A..A+10: round-robin, then almost-full stall at k=5..6, then full on a dest-2 push at k=10.
    localparam logic [3:0]    EXP_POP  [0:10] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001,
                                                  4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0100, 4'b0000};
    localparam logic [3:0]    EXP_PUSH [0:10] = '{4'b0000, 4'b0000, 4'b1000, 4'b0100, 4'b0010,
                                                  4'b0001, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0100};
    localparam logic [DW-1:0] EXP_DATA [0:10] = '{10'h000, 10'h000, 10'h300, 10'h2AB, 10'h1C5,
                                                  10'h0F0, 10'h300, 10'h000, 10'h000, 10'h000, 10'h2AB};

    fifo_arbiter_ctrl #(.DATA_WIDTH(DW), .THR_WIDTH(TW)) dut (
        .clk             (clk),
        .reset           (reset),
        .init            (init),
        .umbral_alto_in  (ua),
        .umbral_bajo_in  (ub),
        .in_empty        (in_empty),
        .in_data         (in_data),
        .in_pop          (in_pop),
        .out_full        (out_full),
        .out_almost_full (out_afull),
        .out_push        (out_push),
        .out_data        (out_data),
        .alto            (alto),
        .bajo            (bajo),
        .state           (state),
        .idle            (idle),
        .error           (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset     = 1'b0;
        init      = 1'b1;
        ua        = 3'd5;
        ub        = 3'd2;
        in_empty  = 4'hF;
        out_full  = 4'h0;
        out_afull = 4'h0;
        in_data   = {10'h0F0, 10'h1C5, 10'h2AB, 10'h300};

        // Reset values
        cyc(); cyc(); mid();
        check("rst_state", 32'(state), 32'd0);
        check("rst_idle", 32'(idle), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_alto", 32'(alto), 32'd6);
        check("rst_bajo", 32'(bajo), 32'd1);
        check("rst_pop", 32'(in_pop), 32'd0);
        check("rst_push", 32'(out_push), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);

        // Release reset with init held: RESET -> INIT -> follow 5/2 -> IDLE
        reset = 1'b1;
        cyc(); mid();
        check("init_state", 32'(state), 32'd1);
        check("init_alto_unchanged", 32'(alto), 32'd6);
        cyc(); mid();
        check("init_follow_alto", 32'(alto), 32'd5);
        check("init_follow_bajo", 32'(bajo), 32'd2);
        cyc();
        init = 1'b0;
        cyc(); mid();
        check("cfg1_state", 32'(state), 32'd2);
        check("cfg1_idle", 32'(idle), 32'd1);
        check("cfg1_alto", 32'(alto), 32'd5);
        check("cfg1_bajo", 32'(bajo), 32'd2);

        // Invalid pair (bajo >= alto) reverts to the last valid one
        init = 1'b1; ua = 3'd3; ub = 3'd5;
        cyc(); mid();
        check("cfg2_enter_init", 32'(state), 32'd1);
        check("cfg2_idle_low", 32'(idle), 32'd0);
        cyc();
        init = 1'b0;
        mid();
        check("cfg2_follow_alto", 32'(alto), 32'd3);
        check("cfg2_follow_bajo", 32'(bajo), 32'd5);
        cyc(); mid();
        check("cfg2_state", 32'(state), 32'd2);
        check("cfg2_keep_alto", 32'(alto), 32'd5);
        check("cfg2_keep_bajo", 32'(bajo), 32'd2);

        // Round-robin with all ports full, then stall, then overflow error
        in_empty = 4'h0;
        for (int k = 0; k <= 10; k++) begin
            cyc();
            if (k == 5)  out_afull = 4'b0010;
            if (k == 7)  out_afull = 4'b0000;
            if (k == 10) out_full  = 4'b0100;
            mid();
            check($sformatf("rr_pop_%0d", k), 32'(in_pop), 32'(EXP_POP[k]));
            check($sformatf("rr_push_%0d", k), 32'(out_push), 32'(EXP_PUSH[k]));
            check($sformatf("rr_state_%0d", k), 32'(state), 32'd3);
            if (EXP_PUSH[k] != 4'b0000)
                check($sformatf("rr_data_%0d", k), 32'(out_data), 32'(EXP_DATA[k]));
        end
        for (int k = 11; k <= 13; k++) begin
            cyc();
            if (k == 12) out_full = 4'b0000;
            mid();
            check($sformatf("err_state_%0d", k), 32'(state), 32'd4);
            check($sformatf("err_flag_%0d", k), 32'(error), 32'd1);
            check($sformatf("err_pop_%0d", k), 32'(in_pop), 32'd0);
            check($sformatf("err_push_%0d", k), 32'(out_push), 32'd0);
        end

        // Reset out of ERROR; equal thresholds at INIT exit fall back to 6/1
        reset = 1'b0; in_empty = 4'hF; ua = 3'd4; ub = 3'd4;
        cyc(); mid();
        check("rst2_state", 32'(state), 32'd0);
        check("rst2_error", 32'(error), 32'd0);
        reset = 1'b1;
        cyc(); mid();
        check("rst2_init", 32'(state), 32'd1);
        cyc(); mid();
        check("rst2_idle", 32'(state), 32'd2);
        check("rst2_alto", 32'(alto), 32'd6);
        check("rst2_bajo", 32'(bajo), 32'd1);

        // Single word 0x300 in port 0 routed to output 3, two cycles after the pop
        in_empty = 4'b1110;
        cyc();
        in_empty = 4'hF;
        mid();
        check("one_pop", 32'(in_pop), 32'b0001);
        check("one_active", 32'(state), 32'd3);
        cyc(); mid();
        check("one_pop_n1", 32'(in_pop), 32'd0);
        check("one_push_n1", 32'(out_push), 32'd0);
        cyc(); mid();
        check("one_push_n2", 32'(out_push), 32'b1000);
        check("one_data_n2", 32'(out_data), 32'h300);
        check("one_state_n2", 32'(state), 32'd3);
        cyc(); mid();
        check("one_back_idle", 32'(state), 32'd2);
        check("one_idle_flag", 32'(idle), 32'd1);
        check("one_push_n3", 32'(out_push), 32'd0);

        // Reset one cycle after a pop aborts the in-flight word
        in_empty = 4'b1110;
        cyc(); mid();
        check("abort_pop", 32'(in_pop), 32'b0001);
        cyc();
        reset = 1'b0; in_empty = 4'hF;
        mid();
        check("abort_push_n1", 32'(out_push), 32'd0);
        cyc(); mid();
        check("abort_push_n2", 32'(out_push), 32'd0);
        check("abort_state", 32'(state), 32'd0);
        check("abort_pop_n2", 32'(in_pop), 32'd0);
        check("abort_data", 32'(out_data), 32'd0);
        check("abort_alto", 32'(alto), 32'd6);
        check("abort_bajo", 32'(bajo), 32'd1);
        cyc(); mid();
        check("abort_push_n3", 32'(out_push), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_arbiter_ctrl.md
# fifo_arbiter_ctrl

- **Role:** controller and arbiter that sits between four input FIFOs and four output FIFOs in the FIFO datapath.
- **Arbitration:** pops the input FIFOs round-robin and routes each word to an output FIFO chosen by the word's two MSBs.
- **Backpressure:** stalls on output backpressure.
- **Thresholds:** owns the almost-full/almost-empty thresholds, which it drives to every FIFO.
- **Error:** flags a push into a full FIFO.

## Interface
Parameters:
- DATA_WIDTH, 10, FIFO word width; bits [DATA_WIDTH-1:DATA_WIDTH-2] are the destination index.
- THR_WIDTH, 3, threshold width (FIFO depth 8).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low.
- init  in  1  request threshold (re)configuration.
- umbral_alto_in  in  THR_WIDTH  almost-full threshold to load.
- umbral_bajo_in  in  THR_WIDTH  almost-empty threshold to load.
- in_empty  in  4  empty flags of the input FIFOs.
- in_data  in  4*DATA_WIDTH  input FIFO read data; slot i = [i*DATA_WIDTH +: DATA_WIDTH].
- in_pop  out  4  one-hot pop, registered.
- out_full  in  4  full flags of the output FIFOs.
- out_almost_full  in  4  almost-full flags of the output FIFOs.
- out_push  out  4  one-hot push, registered.
- out_data  out  DATA_WIDTH  word to write, registered.
- alto  out  THR_WIDTH  configured almost-full threshold (to all FIFOs).
- bajo  out  THR_WIDTH  configured almost-empty threshold (to all FIFOs).
- state  out  3  current FSM state.
- idle  out  1  high in IDLE.
- error  out  1  sticky overflow error.

## Operation
- **Reset (reset==0 at a posedge):**
  - state=RESET, all outputs 0 except alto=6, bajo=1.
  - pipeline cleared, round-robin pointer=3 (so port 0 wins first).
- **FSM states:** RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4.
  - RESET→INIT on the first cycle with reset high.
  - INIT: alto/bajo follow umbral_*_in each cycle. Leave to IDLE when init is low.
    - If umbral_bajo_in >= umbral_alto_in at exit, keep the last valid pair (reset values if none).
  - IDLE:
    - → INIT if init=1 (priority).
    - else → ACTIVE if any ~in_empty and no stall.
  - ACTIVE: issue at most one pop per cycle.
    - → IDLE when all in_empty=1 and the pipeline is empty.
    - init is ignored in ACTIVE.
  - ERROR: no pops, no pushes; exit only via reset.
- **Stall:** |out_almost_full or |out_full. No new pop is issued while stalled; in-flight words still complete.
- **Eligibility:** port i is eligible when ~in_empty[i] and i was not popped in either of the two previous cycles. This covers the FIFO's registered empty-flag lag.
- **Grant:** round-robin. Pick the first eligible index after the pointer, cyclically; the pointer updates to the granted index.
- **Routing:** for the popped word, dest = word[DATA_WIDTH-1:DATA_WIDTH-2].
  - out_push = 1<<dest.
  - out_data = the full word, unmodified.
- **Error condition:** out_push[k] asserted while out_full[k]=1.
  - error=1 next cycle, state→ERROR.
  - The offending word is counted as dropped.
- Stall and error take effect even mid-burst. A new reset at any point aborts in-flight words; nothing is pushed.

## Timing
- Pop at cycle N (in_pop high during N). The slot is sampled in N+1; out_push/out_data are high/valid during N+2.
  - Pop→push latency: 2 cycles.
  - Max 2 words in flight.
- Throughput: one word per cycle when at least 3 ports are eligible in rotation. With a single active port, one word every 3 cycles.
- Stall is sampled combinationally into the pop decision. A stall seen in cycle N means in_pop=0 in cycle N.
- state, idle and alto/bajo are registered and change the cycle after the transition condition.

## Structure
- **Package fifo_ctrl_pkg:**
  - State encodings.
  - Reset thresholds ALTO_RST=6, BAJO_RST=1.
  - Destination field position.
- **Sub-module rr_arbiter4:**
  - Inputs: eligible mask, pointer.
  - Outputs: one-hot grant, valid.
  - Purely combinational.
- **Top level:** FSM, pointer/holdoff registers, 2-stage pop/push pipeline, threshold registers.

## Test plan
- Reset release, init=1 with alto=5, bajo=2 for 2 cycles, then init=0 → state 0→1→2; alto=5, bajo=2. Then init with bajo=5, alto=3 → thresholds stay 5/2.
- Input FIFO 0 holds 0x300 (dest 3), idle → in_pop=0001 at N; out_push=1000 and out_data=0x300 at N+2; return to IDLE.
- Words in all four inputs → pops granted 0,1,2,3,0 on consecutive cycles; no port is popped within 2 cycles of its last pop.
- out_almost_full[1]=1 during ACTIVE → in_pop=0 that same cycle; the 2 in-flight words are still pushed; popping resumes the cycle after the flag drops.
- out_full[2]=1 while a word with dest 2 reaches the push stage → error=1 and state=4 next cycle; no further pop or push until reset.
- Reset asserted one cycle after a pop → no out_push ever follows; all outputs are at reset values.
